rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way resource among 8 requesters.
- The winner is selected as a 3-bit index and expanded into a one-hot grant, the same 3-to-8 mapping as the team's decoder (index n drives bit n).
- A grant is released when its requester drops req or a hold timeout expires.
- A mandatory one-cycle dead gap separates consecutive owners.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held; legal range 1 .. 2^CNT_W-1.
- CNT_W, 5: width of the hold counter.

Ports:
- clk        input   1  system clock, all state on rising edge
- rst_n      input   1  asynchronous active-low reset
- req        input   8  request vector; bit n = requester n; level, held for the duration of ownership
- gnt        output  8  registered one-hot grant; bit gnt_idx set when gnt_valid=1, else 8'h00
- gnt_idx    output  3  registered index of current/last owner
- gnt_valid  output  1  registered; 1 while a grant is active
- timeout    output  1  registered one-cycle pulse when a grant is forcibly ended by MAX_HOLD

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately, including mid-grant):
  - state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, hold_cnt=0.
  - Priority pointer last=3'd7, so requester 0 has highest priority after reset.
- States: IDLE, GRANT, RELEASE.
- Arbitration (IDLE and RELEASE only):
  - Search req from index last+1 upward, wrapping 7->0; first set bit wins.
  - Pure combinational priority search, evaluated every cycle in those states.
- IDLE:
  - req==0: stay IDLE.
  - Otherwise at the edge: gnt_idx<=winner, gnt_valid<=1, gnt<=one-hot(winner), hold_cnt<=1, ->GRANT.
  - Latency: req sampled at edge N, grant visible from edge N onward (one registered cycle).
- GRANT:
  - Only req[gnt_idx] is examined; other req bits are ignored, no preemption.
  - If req[gnt_idx]==0 at the edge: ->RELEASE, gnt<=0, gnt_valid<=0, timeout<=0, last<=gnt_idx.
  - Else if hold_cnt==MAX_HOLD: ->RELEASE, gnt<=0, gnt_valid<=0, timeout<=1, last<=gnt_idx.
  - Else: hold_cnt<=hold_cnt+1, outputs unchanged.
  - Drop and timeout in the same cycle: drop takes precedence, timeout stays 0.
  - Max grant width is exactly MAX_HOLD cycles.
- RELEASE:
  - Always exactly one cycle with gnt=0, gnt_valid=0.
  - timeout is high during this cycle only if entered via timeout; cleared at the next edge.
  - Arbitrates with the updated pointer. Any req: ->GRANT as in IDLE, so the next grant is visible the cycle after RELEASE. No req: ->IDLE.
  - A requester that timed out but still holds req is re-granted only after all other active requesters have been served.
- gnt_idx keeps the last owner while gnt_valid=0. gnt is always 8'h00 or one-hot, never multi-hot.
- hold_cnt saturates logic-wise at MAX_HOLD and never wraps.
- Unknown/illegal state encoding: ->IDLE with outputs cleared.

Test Plan:
1. Assert rst_n=0 during activity with req=8'hFF -> all outputs 0 immediately, before any clk edge. Release reset; the first grant goes to requester 0 (gnt=8'h01).
2. MAX_HOLD=16: req=8'h08 for 3 cycles then req=0 -> gnt=8'h08, gnt_idx=3 for exactly 3 cycles, then gnt=8'h00, timeout never asserted, state returns to IDLE.
3. MAX_HOLD=4: req=8'hFF held constant -> grant sequence 0,1,2,...,7,0.
   - Each grant 4 cycles, separated by one gnt=8'h00 cycle.
   - timeout pulses once in each gap; period 5 cycles per requester.
4. Fairness and wrap: after requester 7 is served, req=8'h81 -> next grant gnt=8'h01. Then req[0] drops -> next grant gnt=8'h80.
5. MAX_HOLD=4: req[2] deasserted in the 4th grant cycle (hold_cnt==4) -> RELEASE with timeout=0. A req[2]-only re-request is granted again the cycle after RELEASE.
6. Grant to requester 5 active; raise req[1] mid-grant -> no change to gnt=8'h20 until req[5] drops. Then one gap cycle, then gnt=8'h02.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Purpose : round-robin arbiter granting one 8-way resource to one of 8 requesters,
//           with a hold timeout and a mandatory one-cycle dead gap between owners.
// Latency : req sampled at a rising edge is reflected in the registered grant right after that edge.
//           Backpressure: none; a requester holds req for as long as it wants ownership,
//           and the arbiter revokes ownership after MAX_HOLD cycles.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   req[7:0]   level request vector, bit n = requester n
//   gnt[7:0]   registered one-hot grant (8'h00 while no grant is active)
//   gnt_idx    registered index of the current or most recent owner
//   gnt_valid  registered, high while a grant is active
//   timeout    registered one-cycle pulse, high in the gap cycle after a forced release

module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [2:0]         last, last_nxt;
  logic [7:0]         gnt_nxt;
  logic [2:0]         gnt_idx_nxt;
  logic               gnt_valid_nxt;
  logic               timeout_nxt;

  logic               win_vld;
  logic [2:0]         win_idx;

  // Same 3-to-8 mapping as the shared decoder: index n drives bit n.
  function automatic logic [7:0] dec3to8(input logic [2:0] idx);
    dec3to8 = 8'h01 << idx;
  endfunction

  // Rotating priority search starting just above the last owner. Offset 8
  // wraps back to the last owner itself, so it only wins when it is the sole
  // requester; that is what makes a timed-out holder wait its turn.
  always_comb begin
    logic [2:0] cand;
    win_vld = 1'b0;
    win_idx = last;
    cand    = last;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and next-output logic. timeout defaults low so it can only
  // ever be a single-cycle pulse.
  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    last_nxt      = last;
    gnt_nxt       = gnt;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;

    unique case (state)
      IDLE, RELEASE: begin
        if (win_vld) begin
          state_nxt     = GRANT;
          gnt_idx_nxt   = win_idx;
          gnt_valid_nxt = 1'b1;
          gnt_nxt       = dec3to8(win_idx);
          hold_cnt_nxt  = ONE_CNT;
        end else begin
          state_nxt     = IDLE;
          gnt_nxt       = 8'h00;
          gnt_valid_nxt = 1'b0;
        end
      end

      GRANT: begin
        // Only the owner's request matters here; nobody can preempt it.
        if (!req[gnt_idx]) begin
          // A voluntary drop wins over a coincident timeout.
          state_nxt     = RELEASE;
          gnt_nxt       = 8'h00;
          gnt_valid_nxt = 1'b0;
          last_nxt      = gnt_idx;
        end else if (hold_cnt >= MAX_CNT) begin
          state_nxt     = RELEASE;
          gnt_nxt       = 8'h00;
          gnt_valid_nxt = 1'b0;
          timeout_nxt   = 1'b1;
          last_nxt      = gnt_idx;
        end else begin
          hold_cnt_nxt  = hold_cnt + ONE_CNT;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle.
        state_nxt     = IDLE;
        hold_cnt_nxt  = '0;
        gnt_nxt       = 8'h00;
        gnt_idx_nxt   = 3'd0;
        gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      last      <= 3'd7;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      last      <= last_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Output invariants: grant is never multi-hot and always agrees with the
  // valid flag and the index.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));
  a_gnt_matches : assert property (@(posedge clk) disable iff (!rst_n)
    gnt == (gnt_valid ? dec3to8(gnt_idx) : 8'h00));

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       to_a, to_b;

  int n_total = 0;
  int n_pass  = 0;

  rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) u_h16 (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .timeout(to_a)
  );

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(5)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic t);
    chk({tag, ".gnt"}, gnt_a, g);
    chk({tag, ".idx"}, 8'(idx_a), 8'(i));
    chk({tag, ".vld"}, 8'(vld_a), 8'(v));
    chk({tag, ".to"},  8'(to_a),  8'(t));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic t);
    chk({tag, ".gnt"}, gnt_b, g);
    chk({tag, ".idx"}, 8'(idx_b), 8'(i));
    chk({tag, ".vld"}, 8'(vld_b), 8'(v));
    chk({tag, ".to"},  8'(to_b),  8'(t));
  endtask

  initial begin
    // Vectors for the MAX_HOLD=16 instance: req applied before the edge,
    // outputs expected just after it.
    // Release after the post-reset grant to 0, then idle.
    tbl.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
    // Requester 3 for exactly three cycles, no timeout, back to idle.
    tbl.push_back('{8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
    tbl.push_back('{8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
    tbl.push_back('{8'h08, 8'h08, 3'd3, 1'b1, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd3, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd3, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd3, 1'b0, 1'b0});
    // Serve 7, then 0|7 requesting wraps to 0, then 7 after 0 drops.
    tbl.push_back('{8'h80, 8'h80, 3'd7, 1'b1, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd7, 1'b0, 1'b0});
    tbl.push_back('{8'h81, 8'h01, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{8'h81, 8'h01, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{8'h80, 8'h00, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{8'h80, 8'h80, 3'd7, 1'b1, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd7, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd7, 1'b0, 1'b0});
    // Requester 5 owns; requester 1 arrives mid-grant and must wait.
    tbl.push_back('{8'h20, 8'h20, 3'd5, 1'b1, 1'b0});
    tbl.push_back('{8'h20, 8'h20, 3'd5, 1'b1, 1'b0});
    tbl.push_back('{8'h22, 8'h20, 3'd5, 1'b1, 1'b0});
    tbl.push_back('{8'h22, 8'h20, 3'd5, 1'b1, 1'b0});
    tbl.push_back('{8'h02, 8'h00, 3'd5, 1'b0, 1'b0});
    tbl.push_back('{8'h02, 8'h02, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd1, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 3'd1, 1'b0, 1'b0});

    rst_n = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    step();
    step();
    chk_a("rst_h16", 8'h00, 3'd0, 1'b0, 1'b0);
    chk_b("rst_h4",  8'h00, 3'd0, 1'b0, 1'b0);

    // Reset during activity: outputs must clear before any clock edge.
    rst_n = 1'b1;
    req_a = 8'hFF;
    step();
    chk_a("first_gnt", 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    step();
    chk_a("held_gnt", 8'h01, 3'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_a("post_rst_gnt", 8'h01, 3'd0, 1'b1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i].req;
      step();
      chk_a($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to);
    end

    // MAX_HOLD=4, all requesting: 0..7 then 0, four grant cycles each, then a
    // gap cycle carrying the timeout pulse.
    req_b = 8'hFF;
    for (int r = 0; r <= 8; r++) begin
      logic [2:0] exp_idx;
      exp_idx = 3'(r % 8);
      for (int c = 1; c <= 4; c++) begin
        step();
        chk_b($sformatf("rr%0d.c%0d", r, c), 8'h01 << exp_idx, exp_idx, 1'b1, 1'b0);
      end
      step();
      chk_b($sformatf("rr%0d.gap", r), 8'h00, exp_idx, 1'b0, 1'b1);
    end
    req_b = 8'h00;
    step();
    chk_b("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // MAX_HOLD=4: drop in the 4th cycle is a normal release, not a timeout.
    req_b = 8'h04;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk_b($sformatf("drop4.c%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    req_b = 8'h00;
    step();
    chk_b("drop4.rel", 8'h00, 3'd2, 1'b0, 1'b0);
    req_b = 8'h04;
    step();
    chk_b("drop4.regnt", 8'h04, 3'd2, 1'b1, 1'b0);
    // Keep holding: forced release after 4 cycles, then sole requester re-granted.
    for (int c = 2; c <= 4; c++) begin
      step();
      chk_b($sformatf("hold4.c%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step();
    chk_b("hold4.to", 8'h00, 3'd2, 1'b0, 1'b1);
    step();
    chk_b("hold4.regnt", 8'h04, 3'd2, 1'b1, 1'b0);
    req_b = 8'h00;
    step();
    chk_b("hold4.rel", 8'h00, 3'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
